// File: rtl/cuppa_acq_ctrl_if.sv
// Waveform-buffer write port and event-header handshake between the acquisition sequencer
// and readout.
interface cuppa_acq_ctrl_if;
  logic        wr_en;
  logic [23:0] wr_data;
  logic        wr_last;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_src;
  logic [31:0] evt_ts;

  modport master (
    output wr_en, wr_data, wr_last, evt_valid, evt_src, evt_ts,
    input  evt_ready
  );

  modport slave (
    input  wr_en, wr_data, wr_last, evt_valid, evt_src, evt_ts,
    output evt_ready
  );
endinterface

// File: rtl/cuppa_acq_ctrl.sv
// Acquisition sequencer: pre-trigger delay line, capture window, event header and holdoff.
// Define CUPPA_ACQ_AUTO_REARM_EN for continuous acquisition; otherwise each event needs an arm.
module cuppa_acq_ctrl #(
    parameter int unsigned PRE_LEN = 8,
    parameter int unsigned LEN_W   = 10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                arm_i,
    input  logic                disarm_i,
    input  logic                trig_i,
    input  logic [1:0]          trig_src_i,
    input  logic [11:0]         adc_stream_in_0_i,
    input  logic [11:0]         adc_stream_in_1_i,
    input  logic [LEN_W-1:0]    post_len_i,
    input  logic [15:0]         holdoff_len_i,
    cuppa_acq_ctrl_if.master    acq_if,
    output logic                busy_o,
    output logic [15:0]         trig_dropped_o
);

    // Shared down-counter for fill, capture window and holdoff.
    localparam int unsigned CntW = (LEN_W + 7 > 16) ? LEN_W + 7 : 16;

`ifdef CUPPA_ACQ_AUTO_REARM_EN
    localparam bit AutoRearm = 1'b1;
`else
    localparam bit AutoRearm = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StArmed,
        StCapture,
        StEvt,
        StHoldoff
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              pend_q;
    logic              busy_q;
    logic              wr_en_q;
    logic [23:0]       wr_data_q;
    logic              wr_last_q;
    logic              evt_valid_q;
    logic [1:0]        evt_src_q;
    logic [31:0]       evt_ts_q;
    logic [15:0]       drop_q;
    logic [31:0]       ts_q;
    logic [23:0]       dly_q [PRE_LEN+1];
    logic              trig_rej;

    assign trig_rej = state_q inside {StFill, StCapture, StEvt, StHoldoff};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i <= int'(PRE_LEN); i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= {adc_stream_in_1_i, adc_stream_in_0_i};
            for (int i = 1; i <= int'(PRE_LEN); i++) dly_q[i] <= dly_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) ts_q <= '0;
        else         ts_q <= ts_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_last_q   <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_src_q   <= '0;
            evt_ts_q    <= '0;
            drop_q      <= '0;
        end else begin
            wr_en_q   <= 1'b0;
            wr_last_q <= 1'b0;
            if (trig_i && trig_rej && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;

            unique case (state_q)
                StIdle: begin
                    if (arm_i && !disarm_i) begin
                        state_q <= StFill;
                        cnt_q   <= CntW'(PRE_LEN - 1);
                        busy_q  <= 1'b1;
                    end
                end
                StFill: begin
                    if (disarm_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= StArmed;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StArmed: begin
                    if (disarm_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (trig_i) begin
                        state_q   <= StCapture;
                        cnt_q     <= CntW'(PRE_LEN) + CntW'(post_len_i) - CntW'(1);
                        evt_src_q <= trig_src_i;
                        evt_ts_q  <= ts_q;
                    end
                end
                StCapture: begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= dly_q[PRE_LEN];
                    if (disarm_i) pend_q <= 1'b1;
                    if (cnt_q == '0) begin
                        wr_last_q <= 1'b1;
                        state_q   <= StEvt;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StEvt: begin
                    evt_valid_q <= 1'b1;
                    if (disarm_i) pend_q <= 1'b1;
                    // evt_valid_q gates the handshake so an early ready is ignored.
                    if (evt_valid_q && acq_if.evt_ready) begin
                        evt_valid_q <= 1'b0;
                        if (pend_q || disarm_i || (holdoff_len_i == 16'd0 && !AutoRearm)) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            pend_q  <= 1'b0;
                        end else if (holdoff_len_i == 16'd0) begin
                            state_q <= StArmed;
                        end else begin
                            state_q <= StHoldoff;
                            cnt_q   <= CntW'(holdoff_len_i) - CntW'(1);
                        end
                    end
                end
                StHoldoff: begin
                    if (disarm_i) pend_q <= 1'b1;
                    if (cnt_q == '0) begin
                        if (pend_q || disarm_i || !AutoRearm) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            pend_q  <= 1'b0;
                        end else begin
                            state_q <= StArmed;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign acq_if.wr_en     = wr_en_q;
    assign acq_if.wr_data   = wr_data_q;
    assign acq_if.wr_last   = wr_last_q;
    assign acq_if.evt_valid = evt_valid_q;
    assign acq_if.evt_src   = evt_src_q;
    assign acq_if.evt_ts    = evt_ts_q;
    assign busy_o           = busy_q;
    assign trig_dropped_o   = drop_q;

endmodule

// File: tb/tb_cuppa_acq_ctrl.sv
// Randomized bench for cuppa_acq_ctrl against an event-timeline reference model.
module tb_cuppa_acq_ctrl;

    localparam int unsigned PreLen   = 8;
    localparam int unsigned LenW     = 10;
    localparam int          HistSize = 4096;
`ifdef CUPPA_ACQ_AUTO_REARM_EN
    localparam bit Auto = 1'b1;
`else
    localparam bit Auto = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            arm, disarm, trig;
    logic [1:0]      trig_src;
    logic [11:0]     adc0, adc1;
    logic [LenW-1:0] post_len;
    logic [15:0]     holdoff_len;
    logic            busy;
    logic [15:0]     trig_dropped;
    bit              ramp;

    always #5 clk = ~clk;

    cuppa_acq_ctrl_if acq_if ();

    cuppa_acq_ctrl #(.PRE_LEN(PreLen), .LEN_W(LenW)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .arm_i             (arm),
        .disarm_i          (disarm),
        .trig_i            (trig),
        .trig_src_i        (trig_src),
        .adc_stream_in_0_i (adc0),
        .adc_stream_in_1_i (adc1),
        .post_len_i        (post_len),
        .holdoff_len_i     (holdoff_len),
        .acq_if            (acq_if),
        .busy_o            (busy),
        .trig_dropped_o    (trig_dropped)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          edge_n = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    // Model: activity is described by edge numbers (arm, trigger T, window N, handshake).
    logic [23:0] hist [HistSize];
    int          rst_edge = 0;
    logic [31:0] m_ts;
    bit          m_act, m_evt, m_hold, m_pend;
    int          m_acc_from, m_T, m_N, m_hold_end;
    bit          e_wr_en, e_last, e_vld, e_busy;
    logic [23:0] e_wr_data;
    logic [1:0]  e_src;
    logic [31:0] e_ts;
    logic [15:0] e_drop;

    function automatic logic [23:0] samp(input int i);
        if (i <= rst_edge) return 24'd0;
        return hist[i % HistSize];
    endfunction

    task automatic model_edge();
        logic [31:0] cur_ts;
        int          h;
        if (!rst_n) begin
            rst_edge = edge_n;
            m_ts = '0; m_act = 0; m_evt = 0; m_hold = 0; m_pend = 0;
            e_wr_en = 0; e_last = 0; e_vld = 0; e_busy = 0;
            e_wr_data = '0; e_src = '0; e_ts = '0; e_drop = '0;
            return;
        end
        cur_ts  = m_ts;
        m_ts    = m_ts + 32'd1;
        hist[edge_n % HistSize] = {adc1, adc0};
        e_wr_en = 0;
        e_last  = 0;
        if (!m_act) begin
            if (arm && !disarm) begin
                m_act = 1; m_evt = 0; m_hold = 0; m_pend = 0;
                m_acc_from = edge_n + int'(PreLen) + 1;
            end
        end else if (m_evt) begin
            if (trig && e_drop != 16'hFFFF) e_drop++;
            if (disarm) m_pend = 1;
            if (edge_n <= m_T + m_N) begin
                e_wr_en   = 1;
                e_wr_data = samp(m_T - int'(PreLen) + (edge_n - m_T - 1));
                e_last    = (edge_n == m_T + m_N);
            end else if (!e_vld) begin
                e_vld = 1;
            end else if (acq_if.evt_ready) begin
                e_vld = 0;
                m_evt = 0;
                h = int'(holdoff_len);
                if (m_pend) m_act = 0;
                else if (h == 0) begin
                    if (Auto) m_acc_from = edge_n + 1;
                    else      m_act = 0;
                end else begin
                    m_hold = 1;
                    m_hold_end = edge_n + h;
                    m_acc_from = edge_n + h + 1;
                end
            end
        end else if (edge_n < m_acc_from) begin
            if (trig && e_drop != 16'hFFFF) e_drop++;
            if (m_hold) begin
                if (disarm) m_pend = 1;
                if (edge_n == m_hold_end) begin
                    m_hold = 0;
                    if (m_pend || !Auto) m_act = 0;
                end
            end else if (disarm) begin
                m_act = 0;
            end
        end else begin
            if (disarm) m_act = 0;
            else if (trig) begin
                m_evt = 1; m_pend = 0;
                m_T   = edge_n;
                m_N   = int'(PreLen) + int'(post_len);
                e_src = trig_src;
                e_ts  = cur_ts;
            end
        end
        if (!m_act) m_pend = 0;
        e_busy = m_act;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("wr_en",        32'(acq_if.wr_en),     32'(e_wr_en));
        check_eq("wr_last",      32'(acq_if.wr_last),   32'(e_last));
        check_eq("wr_data",      32'(acq_if.wr_data),   32'(e_wr_data));
        check_eq("evt_valid",    32'(acq_if.evt_valid), 32'(e_vld));
        check_eq("evt_src",      32'(acq_if.evt_src),   32'(e_src));
        check_eq("evt_ts",       acq_if.evt_ts,         e_ts);
        check_eq("busy",         32'(busy),             32'(e_busy));
        check_eq("trig_dropped", 32'(trig_dropped),     32'(e_drop));
        edge_n++;
    endtask

    task automatic cyc(input bit a, input bit d, input bit t, input bit r);
        arm = a; disarm = d; trig = t; acq_if.evt_ready = r;
        trig_src = 2'($urandom_range(3));
        if (ramp) begin
            adc0 = 12'(edge_n);
            adc1 = 12'(edge_n >> 12);
        end else begin
            adc0 = 12'($urandom);
            adc1 = 12'($urandom);
        end
        step();
    endtask

    initial begin
        int p_arm, p_dis, p_trig, p_rdy, p_rst;
        rst_n = 1'b0; ramp = 1'b1;
        post_len = 10'd4; holdoff_len = 16'd0;
        repeat (3) cyc(0, 0, 0, 0);
        rst_n = 1'b1;

        // Ramp event with a stalled header, then a late ready pulse.
        repeat (5) cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        repeat (PreLen + 5) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        repeat (PreLen + 4 + 20) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        repeat (10) cyc(0, 0, 1, 0);

        // Arm with disarm in IDLE; then trigger on the final fill cycle.
        cyc(1, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (PreLen - 1) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);

        // Disarm in the middle of a capture window.
        holdoff_len = 16'd5;
        cyc(1, 0, 0, 0);
        repeat (PreLen + 2) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (15) cyc(0, 0, 0, 1);
        repeat (5) cyc(0, 0, 1, 1);

        // Holdoff 50 with a trigger every cycle.
        holdoff_len = 16'd50;
        repeat (400) cyc(1, 0, 1, 1);
        repeat (80) cyc(0, 0, 0, 1);

        ramp = 1'b0;
        for (int ph = 0; ph < 8; ph++) begin
            p_arm  = int'($urandom_range(30));
            p_dis  = int'($urandom_range(4));
            p_trig = int'($urandom_range(100));
            p_rdy  = 5 + int'($urandom_range(95));
            p_rst  = (ph == 5) ? 3 : 0;
            for (int c = 0; c < 900; c++) begin
                rst_n = !(int'($urandom_range(999)) < p_rst);
                post_len = ($urandom_range(24) == 0) ? LenW'($urandom_range(300))
                                                      : LenW'($urandom_range(12));
                holdoff_len = 16'($urandom_range(20));
                cyc(int'($urandom_range(99)) < p_arm, int'($urandom_range(99)) < p_dis,
                    int'($urandom_range(99)) < p_trig, int'($urandom_range(99)) < p_rdy);
            end
            rst_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
